reg_cmd_sequencer: RTL and testbench

- Sits directly upstream of the channel register block.
- Consumes 32-bit command words arriving from the Master FPGA link on a valid/ready stream.
- Drives the register block's `reg_num_le` / `wr_en` / `rd_en` strobes and shared data bus, and captures readback words.
- Returns readback data plus a status trailer on an outgoing valid/ready stream.
- Executes burst reads and writes over consecutive register numbers and detects bad opcodes, illegal register numbers and stalled write bursts.

---
 rtl/reg_cmd_sequencer_if.sv | 48 ++++
 rtl/reg_cmd_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_reg_cmd_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// reg_cmd_sequencer_if
//
// Purpose:
//   Bundles the three buses the command sequencer works with: the command
//   stream from the Master FPGA link, the response stream back to it, and the
//   strobe/data bus to the channel register block.
//
// Signals:
//   rx_word/rx_valid/rx_ready      incoming command/data words (valid/ready)
//   tx_word/tx_valid/tx_ready      outgoing readback data and trailers
//   reg_rx_data                    data bus to the register block
//   reg_num_le/reg_wr_en/reg_rd_en register block strobes
//   reg_tx_data                    register block readback word
//   illegal_reg_num                register block "bad register number" flag
//
// Modports:
//   master  the sequencer side (drives strobes, rx_ready and the tx stream)
//   slave   the environment side (link endpoints and register block)
// -----------------------------------------------------------------------------
interface reg_cmd_sequencer_if;
  logic [31:0] rx_word;
  logic        rx_valid;
  logic        rx_ready;

  logic [31:0] tx_word;
  logic        tx_valid;
  logic        tx_ready;

  logic [31:0] reg_rx_data;
  logic        reg_num_le;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_tx_data;
  logic        illegal_reg_num;

  modport master (
    input  rx_word, rx_valid, tx_ready, reg_tx_data, illegal_reg_num,
    output rx_ready, tx_word, tx_valid, reg_rx_data, reg_num_le,
           reg_wr_en, reg_rd_en
  );

  modport slave (
    output rx_word, rx_valid, tx_ready, reg_tx_data, illegal_reg_num,
    input  rx_ready, tx_word, tx_valid, reg_rx_data, reg_num_le,
           reg_wr_en, reg_rd_en
  );
endinterface

// File: rtl/reg_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// reg_cmd_sequencer
//
// Purpose:
//   Sits directly upstream of the channel register block. Consumes command
//   words from the Master FPGA link, executes burst register writes and reads
//   over consecutive register numbers, and returns readback words followed by
//   a single status trailer per accepted header.
//
//   Command:  header {op[3:0], ignored[11:0], count[15:0]}, start register A,
//             then count data words for writes (op 1 = write, op 2 = read).
//   Trailer:  {op[3:0], err[3:0], 8'h00, done[15:0]}
//             err[0] bad opcode, err[1] illegal register, err[2] write
//             timeout, err[3] reserved 0; done = words written or read.
//
// Parameters:
//   TIMEOUT_CYCLES  max clk cycles to wait for a write/drain data word
//                   (must fit in 24 bits).
//
// Ports:
//   clk      interconnect clock, the only clock
//   reset_n  synchronous active-low reset
//   bus      reg_cmd_sequencer_if.master (rx stream, tx stream, register bus)
//   busy     high in every state except IDLE
// -----------------------------------------------------------------------------
module reg_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1250000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  reg_cmd_sequencer_if.master        bus,
  output logic                       busy
);

  localparam logic [3:0] OP_WR = 4'h1;
  localparam logic [3:0] OP_RD = 4'h2;

  localparam logic [23:0] TMO_LIMIT = TIMEOUT_CYCLES[23:0];

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_GET_ADDR   = 4'd1;
  localparam logic [3:0] S_LOAD       = 4'd2;
  localparam logic [3:0] S_CHECK      = 4'd3;
  localparam logic [3:0] S_WR_WAIT    = 4'd4;
  localparam logic [3:0] S_WR_STROBE  = 4'd5;
  localparam logic [3:0] S_RD_STROBE  = 4'd6;
  localparam logic [3:0] S_RD_CAPTURE = 4'd7;
  localparam logic [3:0] S_RD_SEND    = 4'd8;
  localparam logic [3:0] S_DRAIN      = 4'd9;
  localparam logic [3:0] S_TRAILER    = 4'd10;

  logic [3:0]  state_q, state_d;
  logic [3:0]  op_q,    op_d;      // opcode of the command in flight
  logic [15:0] cnt_q,   cnt_d;     // requested word count N
  logic [31:0] addr_q,  addr_d;    // current register number
  logic [15:0] done_q,  done_d;    // words actually written or read
  logic [2:0]  err_q,   err_d;     // sticky error bits err[2:0]
  logic [23:0] tmo_q,   tmo_d;     // cycles spent waiting for a data word
  logic [15:0] drain_q, drain_d;   // words still to discard in DRAIN
  logic [31:0] bus_q,   bus_d;     // last value driven on reg_rx_data
  logic [31:0] txw_q,   txw_d;     // captured readback word
  logic        run_q;              // low for the cycle following a reset edge

  logic        rx_fire;
  logic        tx_fire;
  logic        tmo_hit;
  logic        last_word;

  // ---------------------------------------------------------------------------
  // Handshakes and output decode
  // ---------------------------------------------------------------------------
  // rx_ready depends only on state, never on rx_valid, so the upstream side can
  // hold a word without any combinational loop through this block.
  assign bus.rx_ready = run_q && ((state_q == S_IDLE)    ||
                                  (state_q == S_GET_ADDR) ||
                                  (state_q == S_WR_WAIT)  ||
                                  (state_q == S_DRAIN));

  assign rx_fire = bus.rx_valid && bus.rx_ready;

  assign bus.tx_valid = (state_q == S_RD_SEND) || (state_q == S_TRAILER);
  assign tx_fire      = bus.tx_valid && bus.tx_ready;

  // The trailer is built from registers that cannot change while TRAILER
  // waits for tx_ready, so tx_word stays stable under backpressure.
  assign bus.tx_word = (state_q == S_TRAILER) ?
                       {op_q, 1'b0, err_q, 8'h00, done_q} : txw_q;

  assign bus.reg_num_le = (state_q == S_LOAD);
  assign bus.reg_wr_en  = (state_q == S_WR_STROBE);
  assign bus.reg_rd_en  = (state_q == S_RD_STROBE);

  // During LOAD the address appears on the bus in the same cycle as the strobe;
  // otherwise the bus shows the held register (write data lands there on
  // accept, so it is already stable for WR_STROBE).
  assign bus.reg_rx_data = (state_q == S_LOAD) ? addr_q : bus_q;

  assign busy = (state_q != S_IDLE);

  assign tmo_hit   = ((tmo_q + 24'd1) == TMO_LIMIT);
  assign last_word = ((done_q + 16'd1) == cnt_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement; a path
    // that left one unassigned would infer a latch.
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    done_d  = done_q;
    err_d   = err_q;
    drain_d = drain_q;
    bus_d   = bus_q;
    txw_d   = txw_q;
    // The timeout counter only advances in the two waiting states, so it
    // is zero on every entry to them.
    tmo_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          op_d   = bus.rx_word[31:28];
          cnt_d  = bus.rx_word[15:0];
          done_d = '0;
          err_d  = '0;
          if ((bus.rx_word[31:28] == OP_WR) || (bus.rx_word[31:28] == OP_RD)) begin
            state_d = S_GET_ADDR;
          end else begin
            // No address word follows a bad header; the next word is a header.
            err_d[0] = 1'b1;
            state_d  = S_TRAILER;
          end
        end
      end

      S_GET_ADDR: begin
        if (rx_fire) begin
          addr_d  = bus.rx_word;
          state_d = (cnt_q == 16'd0) ? S_TRAILER : S_LOAD;
        end
      end

      S_LOAD: begin
        bus_d   = addr_q;
        state_d = S_CHECK;
      end

      S_CHECK: begin
        // illegal_reg_num reflects the number latched by the LOAD strobe.
        if (bus.illegal_reg_num) begin
          err_d[1] = 1'b1;
          if (op_q == OP_WR) begin
            // The remaining write data is still on its way and must be consumed
            // so the link stays aligned on command boundaries.
            drain_d = cnt_q - done_q;
            state_d = S_DRAIN;
          end else begin
            state_d = S_TRAILER;
          end
        end else begin
          state_d = (op_q == OP_WR) ? S_WR_WAIT : S_RD_STROBE;
        end
      end

      S_WR_WAIT: begin
        if (rx_fire) begin
          bus_d   = bus.rx_word;
          state_d = S_WR_STROBE;
        end else if (tmo_hit) begin
          err_d[2] = 1'b1;
          state_d  = S_TRAILER;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end

      S_WR_STROBE: begin
        done_d  = done_q + 16'd1;
        addr_d  = addr_q + 32'd1;
        state_d = last_word ? S_TRAILER : S_LOAD;
      end

      S_RD_STROBE: begin
        state_d = S_RD_CAPTURE;
      end

      S_RD_CAPTURE: begin
        // Readback is valid exactly one cycle after reg_rd_en.
        txw_d   = bus.reg_tx_data;
        state_d = S_RD_SEND;
      end

      S_RD_SEND: begin
        if (tx_fire) begin
          done_d  = done_q + 16'd1;
          addr_d  = addr_q + 32'd1;
          state_d = last_word ? S_TRAILER : S_LOAD;
        end
      end

      S_DRAIN: begin
        if (rx_fire) begin
          if (drain_q == 16'd1) begin
            state_d = S_TRAILER;
          end else begin
            drain_d = drain_q - 16'd1;
          end
        end else if (tmo_hit) begin
          err_d[2] = 1'b1;
          state_d  = S_TRAILER;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end

      S_TRAILER: begin
        if (tx_fire) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      tmo_q   <= '0;
      drain_q <= '0;
      bus_q   <= '0;
      txw_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      drain_q <= drain_d;
      bus_q   <= bus_d;
      txw_q   <= txw_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_reg_cmd_sequencer;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  always #4 clk = ~clk;

  reg_cmd_sequencer_if bus();

  reg_cmd_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .busy   (busy)
  );

  typedef logic [31:0] word_q_t [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'h5EED_0000 + 32'(i);
  endfunction

  // ---------------------------------------------------------------------------
  // Register block model: 32 registers, numbers above 31 are illegal.
  // ---------------------------------------------------------------------------
  logic [31:0] regs [32];
  logic [31:0] num_q;
  logic [31:0] le_log [$];
  logic [63:0] wr_log [$];
  int          n_rd_cnt = 0;
  int          overlap_cnt = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
      num_q               <= '0;
      bus.illegal_reg_num <= 1'b0;
      bus.reg_tx_data     <= '0;
    end else begin
      if (bus.reg_num_le) begin
        num_q               <= bus.reg_rx_data;
        bus.illegal_reg_num <= (bus.reg_rx_data > 32'd31);
        le_log.push_back(bus.reg_rx_data);
      end
      if (bus.reg_wr_en) begin
        if (num_q < 32'd32) regs[num_q[4:0]] <= bus.reg_rx_data;
        wr_log.push_back({num_q, bus.reg_rx_data});
      end
      if (bus.reg_rd_en) begin
        bus.reg_tx_data <= (num_q < 32'd32) ? regs[num_q[4:0]] : 32'hDEAD_BEEF;
        n_rd_cnt <= n_rd_cnt + 1;
      end
      if ((int'(bus.reg_num_le) + int'(bus.reg_wr_en) + int'(bus.reg_rd_en)) > 1)
        overlap_cnt <= overlap_cnt + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: what a command should produce, from the command rules.
  // ---------------------------------------------------------------------------
  logic [31:0] shadow [32];

  function automatic void model_cmd(input word_q_t w, output word_q_t resp,
                                    output word_q_t wr_a, output word_q_t wr_d,
                                    output int n_le);
    logic [3:0]  op;
    logic [3:0]  err;
    logic [15:0] done;
    logic [31:0] ra;
    int          n;
    resp.delete(); wr_a.delete(); wr_d.delete();
    n_le = 0;
    op   = w[0][31:28];
    err  = 4'h0;
    done = 16'h0;
    if (op != 4'h1 && op != 4'h2) begin
      resp.push_back({op, 4'h1, 8'h00, 16'h0000});
      return;
    end
    n = int'(w[0][15:0]);
    for (int i = 0; i < n; i++) begin
      ra = w[1] + 32'(i);
      n_le++;
      if (ra > 32'd31) begin
        err = 4'h2;
        break;
      end
      if (op == 4'h1) begin
        shadow[ra[4:0]] = w[2 + i];
        wr_a.push_back(ra);
        wr_d.push_back(w[2 + i]);
      end else begin
        resp.push_back(shadow[ra[4:0]]);
      end
      done++;
    end
    resp.push_back({op, err, 8'h00, done});
  endfunction

  // ---------------------------------------------------------------------------
  // Stream drivers (inputs change and outputs are sampled on negedge)
  // ---------------------------------------------------------------------------
  task automatic send_words(input word_q_t w, input int max_gap);
    foreach (w[k]) begin
      int budget;
      budget = 500;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      bus.rx_word  = w[k];
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!bus.rx_ready) begin
        check("rx_ready_timeout", bus.rx_ready, 1);
        bus.rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic recv_words(input int n, input int hold, output word_q_t got);
    got.delete();
    for (int k = 0; k < n; k++) begin
      int h;
      int budget;
      logic [31:0] held;
      h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
      budget = 500;
      bus.tx_ready = 1'b0;
      while (!bus.tx_valid && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!bus.tx_valid) begin
        check("tx_valid_timeout", bus.tx_valid, 1);
        return;
      end
      held = bus.tx_word;
      repeat (h) begin
        @(negedge clk);
        check("tx_valid_held", bus.tx_valid, 1);
        check("tx_word_stable", bus.tx_word, held);
      end
      bus.tx_ready = 1'b1;
      got.push_back(bus.tx_word);
      @(negedge clk);
      bus.tx_ready = 1'b0;
    end
  endtask

  task automatic run_cmd(input string tag, input word_q_t w, input int gap, input int hold,
                         input word_q_t exp_resp, input word_q_t exp_wa, input word_q_t exp_wd,
                         input int exp_le, input int exp_rd);
    word_q_t got;
    int wr0, le0, rd0;
    wr0 = wr_log.size();
    le0 = le_log.size();
    rd0 = n_rd_cnt;
    fork
      send_words(w, gap);
      recv_words(exp_resp.size(), hold, got);
    join
    check({tag, "_nresp"}, got.size(), exp_resp.size());
    for (int k = 0; k < got.size() && k < exp_resp.size(); k++)
      check({tag, "_resp"}, got[k], exp_resp[k]);
    check({tag, "_n_wr_en"}, wr_log.size() - wr0, exp_wa.size());
    for (int k = 0; k < exp_wa.size() && (wr0 + k) < wr_log.size(); k++)
      check({tag, "_wr"}, wr_log[wr0 + k], {exp_wa[k], exp_wd[k]});
    check({tag, "_n_num_le"}, le_log.size() - le0, exp_le);
    for (int k = 0; k < exp_le && (le0 + k) < le_log.size(); k++)
      check({tag, "_num_le_data"}, le_log[le0 + k], w[1] + 32'(k));
    check({tag, "_n_rd_en"}, n_rd_cnt - rd0, exp_rd);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, bus.rx_ready, 0);
    check({tag, "_tx_valid"}, bus.tx_valid, 0);
    check({tag, "_tx_word"}, bus.tx_word, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_strobes"}, {bus.reg_num_le, bus.reg_wr_en, bus.reg_rd_en}, 0);
    check({tag, "_reg_rx_data"}, bus.reg_rx_data, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int          nw;
    logic [31:0] w [6];
    logic [31:0] trl;
    int          n_le;
    int          n_wr;
    int          n_rd;
    int          nd;
    logic [31:0] d [3];
    int          hold;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  initial begin
    word_q_t w, er, ea, ed, got, m_r, m_a, m_d;
    int      m_le, cyc, budget, saw, wr0;

    vecs[0] = '{4, '{32'h1000_0002, 32'h0000_001e, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0, 32'h0},
                32'h1000_0002, 2, 2, 0, 0, '{32'h0, 32'h0, 32'h0}, -1};
    vecs[1] = '{5, '{32'h1000_0003, 32'h0000_0002, 32'd70000, 32'd100, 32'd100, 32'h0},
                32'h1000_0003, 3, 3, 0, 0, '{32'h0, 32'h0, 32'h0}, -1};
    vecs[2] = '{2, '{32'h2000_0002, 32'h0000_001e, 32'h0, 32'h0, 32'h0, 32'h0},
                32'h2000_0002, 2, 0, 2, 2, '{32'hAAAA_0001, 32'hBBBB_0002, 32'h0}, 0};
    vecs[3] = '{2, '{32'h2000_0002, 32'h0000_001e, 32'h0, 32'h0, 32'h0, 32'h0},
                32'h2000_0002, 2, 0, 2, 2, '{32'hAAAA_0001, 32'hBBBB_0002, 32'h0}, 5};
    vecs[4] = '{2, '{32'h2000_0003, 32'h0000_001f, 32'h0, 32'h0, 32'h0, 32'h0},
                32'h2200_0001, 2, 0, 1, 1, '{32'hBBBB_0002, 32'h0, 32'h0}, -1};
    vecs[5] = '{4, '{32'h1000_0002, 32'h0000_0020, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0},
                32'h1200_0000, 1, 0, 0, 0, '{32'h0, 32'h0, 32'h0}, -1};
    vecs[6] = '{1, '{32'h7000_0005, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                32'h7100_0000, 0, 0, 0, 0, '{32'h0, 32'h0, 32'h0}, -1};
    vecs[7] = '{2, '{32'h1000_0000, 32'h0000_0005, 32'h0, 32'h0, 32'h0, 32'h0},
                32'h1000_0000, 0, 0, 0, 0, '{32'h0, 32'h0, 32'h0}, -1};
    vecs[8] = '{5, '{32'h1000_0003, 32'h0000_001f, 32'h33, 32'h44, 32'h55, 32'h0},
                32'h1200_0001, 2, 1, 0, 0, '{32'h0, 32'h0, 32'h0}, -1};
    vecs[9] = '{2, '{32'h2ABC_0001, 32'h0000_001f, 32'h0, 32'h0, 32'h0, 32'h0},
                32'h2000_0001, 1, 0, 1, 1, '{32'h33, 32'h0, 32'h0}, -1};

    for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
    bus.rx_word  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;

    // Reset: everything low while held, rx_ready the first cycle after release.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("release_rx_ready", bus.rx_ready, 1);
    check("release_busy", busy, 0);

    // Directed table.
    for (int v = 0; v < NVEC; v++) begin
      w.delete(); er.delete(); ea.delete(); ed.delete();
      for (int k = 0; k < vecs[v].nw; k++) w.push_back(vecs[v].w[k]);
      for (int k = 0; k < vecs[v].nd; k++) er.push_back(vecs[v].d[k]);
      er.push_back(vecs[v].trl);
      for (int k = 0; k < vecs[v].n_wr; k++) begin
        ea.push_back(vecs[v].w[1] + 32'(k));
        ed.push_back(vecs[v].w[2 + k]);
      end
      model_cmd(w, m_r, m_a, m_d, m_le);
      run_cmd($sformatf("vec%0d", v), w, 1, vecs[v].hold, er, ea, ed,
              vecs[v].n_le, vecs[v].n_rd);
    end

    // Write timeout: one data word of two, then silence.
    w = '{32'h1000_0002, 32'h0000_0005, 32'hCAFE_0001};
    wr0 = wr_log.size();
    send_words(w, 0);
    cyc = 0;
    budget = 200;
    while (!bus.tx_valid && budget > 0) begin
      if (bus.rx_ready) cyc++;
      @(negedge clk);
      budget--;
    end
    check("wr_tmo_wait_cycles", cyc, TMO);
    recv_words(1, 0, got);
    check("wr_tmo_nresp", got.size(), 1);
    if (got.size() > 0) check("wr_tmo_trailer", got[0], 32'h1400_0001);
    check("wr_tmo_n_wr_en", wr_log.size() - wr0, 1);
    shadow[5] = 32'hCAFE_0001;

    // Drain timeout: illegal start register, data never arrives.
    w = '{32'h1000_0002, 32'h0000_0020};
    send_words(w, 0);
    recv_words(1, 0, got);
    check("drain_tmo_nresp", got.size(), 1);
    if (got.size() > 0) check("drain_tmo_trailer", got[0], 32'h1600_0000);

    // Reset mid-read, with the first data word held on tx.
    w = '{32'h2000_0003, 32'h0000_0000};
    send_words(w, 0);
    budget = 50;
    while (!bus.tx_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("midrst_tx_valid", bus.tx_valid, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_release_rx_ready", bus.rx_ready, 1);
    bus.tx_ready = 1'b1;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tx_valid || busy) saw++;
    end
    bus.tx_ready = 1'b0;
    check("midrst_no_trailer", saw, 0);
    for (int i = 0; i < 32; i++) shadow[i] = init_val(i);

    // Randomized commands against the reference model.
    for (int t = 0; t < 150; t++) begin
      logic [3:0]  op;
      logic [15:0] n;
      logic [31:0] a;
      int          r;
      r  = int'($urandom_range(0, 9));
      op = (r < 4) ? 4'h1 : (r < 8) ? 4'h2 : 4'($urandom_range(0, 15));
      n  = 16'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 31));
        1:       a = 32'($urandom_range(26, 31));
        2:       a = 32'($urandom_range(0, 40));
        default: a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      w.delete();
      w.push_back({op, 12'($urandom), n});
      if (op == 4'h1 || op == 4'h2) begin
        w.push_back(a);
        if (op == 4'h1)
          for (int k = 0; k < int'(n); k++) w.push_back($urandom);
      end
      model_cmd(w, m_r, m_a, m_d, m_le);
      run_cmd($sformatf("rnd%0d", t), w, 3, -1, m_r, m_a, m_d, m_le,
              (op == 4'h2) ? m_r.size() - 1 : 0);
    end

    check("strobe_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
